mcf_rr_drain: RTL and testbench

- Drain stage directly downstream of the per-channel FIFOs in the multi-channel FIFO. It watches CHANNELS FIFO heads through their empty flags and head data, and pops at most one channel per cycle using round-robin arbitration.
- Popped entries are merged onto a single valid/ready output with the source channel id attached.
- A 2-entry output buffer (output register plus skid register) sustains 1 entry/cycle while keeping out_ready_i off the FIFO pop path.

---
 rtl/mcf_pkg.sv | 16 +
 rtl/mcf_rr_arbiter.sv | 47 ++++
 rtl/mcf_rr_drain.sv | 124 ++++++++++++
 tb/tb_mcf_rr_drain.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mcf_pkg.sv
// Shared types and default sizing for the multi-channel FIFO drain path.
// The entry types describe the default configuration.
package mcf_pkg;

  localparam int MCF_CHANNELS   = 4;
  localparam int MCF_DATA_WIDTH = 32;
  localparam int MCF_CH_W       = $clog2(MCF_CHANNELS);

  typedef logic [MCF_CH_W-1:0] ch_id_t;

  typedef struct packed {
    logic [MCF_DATA_WIDTH-1:0] data;
    ch_id_t                    ch;
  } drain_entry_t;

endpackage

// File: rtl/mcf_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just above rr_last
// and wraps upward, using a double-width masked request vector.
module mcf_rr_arbiter
  import mcf_pkg::*;
#(
  parameter int CHANNELS = MCF_CHANNELS,
  parameter int CH_W     = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CH_W-1:0]     rr_last,
  output logic [CHANNELS-1:0] grant,
  output logic [CH_W-1:0]     grant_idx,
  output logic                grant_valid
);

  logic [CHANNELS-1:0]   mask;
  logic [2*CHANNELS-1:0] req_dbl;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
      assign mask[gi] = (CH_W'(gi) > rr_last);
    end
  endgenerate

  // Low half holds only channels above rr_last, high half holds all of
  // them, so the lowest set bit is the next channel in rotation order.
  assign req_dbl = {req, req & mask};

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int j = 2*CHANNELS-1; j >= 0; j--) begin
      if (req_dbl[j]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'((j >= CHANNELS) ? (j - CHANNELS) : j);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mcf_rr_drain.sv
// Round-robin drain of the per-channel FIFO heads onto one valid/ready
// stream, buffered by an output register plus a skid register.
module mcf_rr_drain
  import mcf_pkg::*;
#(
  parameter int CHANNELS   = MCF_CHANNELS,
  parameter int DATA_WIDTH = MCF_DATA_WIDTH,
  parameter int CH_W       = $clog2(CHANNELS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                flush_i,
  input  logic [CHANNELS-1:0]                 ch_empty_i,
  input  logic [CHANNELS-1:0][DATA_WIDTH-1:0] ch_data_i,
  output logic [CHANNELS-1:0]                 ch_pop_o,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [DATA_WIDTH-1:0]               out_data_o,
  output logic [CH_W-1:0]                     out_ch_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CH_W-1:0]       ch;
  } entry_t;

  localparam logic [CH_W-1:0] RR_INIT = CH_W'(CHANNELS - 1);

  entry_t              out_reg, out_next;
  entry_t              skid_reg, skid_next;
  entry_t              pop_entry;
  logic                out_valid_reg, out_valid_next;
  logic                skid_valid_reg, skid_valid_next;
  logic [CH_W-1:0]     rr_last_reg, rr_last_next;

  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [CH_W-1:0]     grant_idx;
  logic                grant_valid;
  logic                can_accept;
  logic                pop_en;
  logic                pop;
  logic                out_free;

  assign req = ~ch_empty_i;

  mcf_rr_arbiter #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W)
  ) u_arbiter (
    .req         (req),
    .rr_last     (rr_last_reg),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Pop eligibility looks only at registered skid state, never out_ready_i.
  assign can_accept = ~skid_valid_reg;
  assign pop_en     = can_accept & ~flush_i & rst_n;
  assign ch_pop_o   = grant & {CHANNELS{pop_en}};
  assign pop        = grant_valid & pop_en;

  assign pop_entry.data = ch_data_i[grant_idx];
  assign pop_entry.ch   = grant_idx;

  assign out_free = ~out_valid_reg | out_ready_i;

  always_comb begin
    out_next        = out_reg;
    out_valid_next  = out_valid_reg;
    skid_next       = skid_reg;
    skid_valid_next = skid_valid_reg;
    rr_last_next    = rr_last_reg;

    if (pop) begin
      rr_last_next = grant_idx;
    end

    if (out_free) begin
      // A valid skid entry is older than anything popped now; pop is 0 here.
      if (skid_valid_reg) begin
        out_next        = skid_reg;
        out_valid_next  = 1'b1;
        skid_valid_next = 1'b0;
      end else if (pop) begin
        out_next       = pop_entry;
        out_valid_next = 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (pop) begin
      skid_next       = pop_entry;
      skid_valid_next = 1'b1;
    end

    if (flush_i) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
      rr_last_next    = RR_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      rr_last_reg    <= RR_INIT;
    end else begin
      out_reg        <= out_next;
      skid_reg       <= skid_next;
      out_valid_reg  <= out_valid_next;
      skid_valid_reg <= skid_valid_next;
      rr_last_reg    <= rr_last_next;
    end
  end

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_reg.data;
  assign out_ch_o    = out_reg.ch;

endmodule

// File: tb/tb_mcf_rr_drain.sv
// Directed bench for mcf_rr_drain: modelled FIFO heads, per-cycle pop and
// valid checks, and a scoreboard monitor on the output stream.
module tb_mcf_rr_drain;

  localparam int CH = 4;
  localparam int DW = 32;
  localparam int CW = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   flush_i = 1'b0;
  logic                   out_ready_i = 1'b1;
  logic [CH-1:0]          ch_empty_i = '1;
  logic [CH-1:0][DW-1:0]  ch_data_i = '0;
  logic [CH-1:0]          ch_pop_o;
  logic                   out_valid_o;
  logic [DW-1:0]          out_data_o;
  logic [CW-1:0]          out_ch_o;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0]    fq [CH][$];
  logic [DW+CW-1:0] exp_q [$];

  logic [CH-1:0] snap_pop;
  logic          snap_valid;
  logic [DW-1:0] snap_data;
  logic [CW-1:0] snap_ch;

  always #5 clk = ~clk;

  mcf_rr_drain #(
    .CHANNELS   (CH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .ch_empty_i  (ch_empty_i),
    .ch_data_i   (ch_data_i),
    .ch_pop_o    (ch_pop_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_ch_o    (out_ch_o)
  );

  function automatic logic [DW-1:0] word(input int ch, input int k);
    logic [DW-1:0] w;
    w       = 32'hD000_0000;
    w[15:8] = ch[7:0];
    w[7:0]  = k[7:0];
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < CH; i++) begin
      ch_empty_i[i] = (fq[i].size() == 0);
      ch_data_i[i]  = (fq[i].size() != 0) ? fq[i][0] : '0;
    end
  endtask

  task automatic load(input int ch, input int k);
    fq[ch].push_back(word(ch, k));
    refresh();
  endtask

  task automatic expect_out(input int ch, input int k);
    exp_q.push_back({word(ch, k), CW'(ch)});
  endtask

  // Sample at the falling edge, then retire popped heads after the rising edge.
  task automatic tick();
    logic [DW-1:0] dummy;
    @(negedge clk);
    snap_pop   = ch_pop_o;
    snap_valid = out_valid_o;
    snap_data  = out_data_o;
    snap_ch    = out_ch_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) begin
      if (snap_pop[i] && fq[i].size() > 0) dummy = fq[i].pop_front();
    end
    refresh();
  endtask

  // seq holds the expected ch_pop_o per tick as nibbles, tick 0 in bits [3:0];
  // vseq holds the expected out_valid_o per tick, tick 0 in bit 0.
  task automatic run_pops(input string name, input int n, input logic [63:0] seq,
                          input logic [15:0] vseq);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s pop t%0d", name, i), 64'(snap_pop), 64'(seq[4*i +: 4]));
      chk($sformatf("%s valid t%0d", name, i), 64'(snap_valid), 64'(vseq[i]));
    end
  endtask

  always @(negedge clk) begin
    logic [DW+CW-1:0] e;
    if (rst_n && !flush_i && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got %0h expected none", {out_data_o, out_ch_o});
      end else begin
        e = exp_q.pop_front();
        chk("out_entry", 64'({out_data_o, out_ch_o}), 64'(e));
      end
    end
  end

  initial begin
    refresh();

    // Reset with every channel loaded: no pops, cleared outputs.
    for (int c = 0; c < CH; c++) begin
      load(c, 0);
      load(c, 1);
    end
    run_pops("reset", 2, 64'h00, 16'h0000);
    chk("reset data", 64'(snap_data), 64'h0);
    chk("reset ch", 64'(snap_ch), 64'h0);

    // All channels busy, ready high: 0,1,2,3,0,1,2,3 back to back.
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < CH; c++) expect_out(c, k);
    run_pops("allbusy", 10, 64'h00_8421_8421, 16'h01FE);

    // Single requester ch2 with five entries.
    for (int k = 0; k < 5; k++) begin
      load(2, k);
      expect_out(2, k);
    end
    run_pops("single", 7, 64'h004_4444, 16'h003E);

    // Stall from the start: ch0 then ch1 popped, then pops stop.
    out_ready_i = 1'b0;
    load(0, 0); load(0, 1); load(1, 0); load(1, 1);
    expect_out(0, 0); expect_out(1, 0); expect_out(0, 1); expect_out(1, 1);
    run_pops("stall", 4, 64'h0021, 16'h000E);
    chk("stall hold data", 64'(snap_data), 64'(word(0, 0)));
    chk("stall hold ch", 64'(snap_ch), 64'h0);
    out_ready_i = 1'b1;
    run_pops("unstall", 5, 64'h00210, 16'h000F);

    // Wrap-around: ch3 granted, then rr_last=3 with req 1001 picks ch0.
    load(3, 0); load(3, 1); load(0, 2); load(0, 3);
    expect_out(3, 0); expect_out(0, 2); expect_out(3, 1); expect_out(0, 3);
    run_pops("wrap", 6, 64'h00_1818, 16'h001E);

    // Flush with out and skid both full; rr_last returns to CHANNELS-1.
    out_ready_i = 1'b0;
    load(0, 4); load(1, 2); load(2, 5); load(3, 2);
    run_pops("preflush", 3, 64'h042, 16'h0006);
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    run_pops("flush", 1, 64'h0, 16'h0001);
    flush_i = 1'b0;
    expect_out(0, 4); expect_out(3, 2);
    run_pops("postflush", 4, 64'h0081, 16'h0006);

    // Reset mid-stream with skid valid.
    out_ready_i = 1'b0;
    load(1, 3); load(2, 6); load(3, 3);
    run_pops("prereset", 3, 64'h042, 16'h0006);
    rst_n = 1'b0;
    load(0, 5);
    run_pops("midreset", 2, 64'h00, 16'h0001);
    chk("midreset data", 64'(snap_data), 64'h0);
    chk("midreset ch", 64'(snap_ch), 64'h0);
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    expect_out(0, 5); expect_out(3, 3);
    run_pops("postreset", 4, 64'h0081, 16'h0006);

    tick();
    tick();
    chk("scoreboard drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
